// File: rtl/cache_write_buffer.sv
// Line-granular write-back buffer between the data cache and main_mem.
// Define WB_COALESCE_EN to merge writes into a matching buffered entry instead of appending.
module cache_write_buffer #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int DEPTH         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_LEN-1:0]                  up_addr,
  input  logic                                 up_rd_req,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]     up_rd_line,
  input  logic                                 up_wr_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     up_wr_line,
  output logic                                 up_gnt,
  output logic [ADDR_LEN-1:0]                  mem_addr,
  output logic                                 mem_rd_req,
  input  logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_rd_line,
  output logic                                 mem_wr_req,
  output logic [32*(1<<LINE_ADDR_LEN)-1:0]     mem_wr_line,
  input  logic                                 mem_gnt,
  output logic [$clog2(DEPTH):0]               buf_count
);
  localparam int LINE_W = 32 * (1 << LINE_ADDR_LEN);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {M_IDLE, M_READ, M_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_LEN-1:0]   addr_q [DEPTH];
  logic [LINE_W-1:0]     line_q [DEPTH];
  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;
  logic [ADDR_LEN-1:0]   rd_addr_q;

  logic                  rd_hit, wr_coal;
  logic [PTR_W-1:0]      rd_hit_idx, wr_coal_idx;
  logic                  rd_take, rd_hit_go, rd_miss_go;
  logic                  wr_take, wr_coal_go, push, pop;

  function automatic logic [PTR_W-1:0] ptr_at(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s -= DEPTH;
    return PTR_W'(s);
  endfunction

  // Walk head -> tail so the last match seen is the youngest.
  always_comb begin
    rd_hit      = 1'b0;
    rd_hit_idx  = '0;
    wr_coal     = 1'b0;
    wr_coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[ptr_at(head_q, i)] && addr_q[ptr_at(head_q, i)] == up_addr) begin
        rd_hit     = 1'b1;
        rd_hit_idx = ptr_at(head_q, i);
`ifdef WB_COALESCE_EN
        if (!(i == 0 && state_q == M_DRAIN)) begin
          wr_coal     = 1'b1;
          wr_coal_idx = ptr_at(head_q, i);
        end
`endif
      end
    end
  end

  always_comb begin
    rd_take    = !up_gnt && up_rd_req && state_q != M_READ;
    rd_hit_go  = rd_take && rd_hit;
    rd_miss_go = rd_take && !rd_hit && state_q == M_IDLE;
    pop        = state_q == M_DRAIN && mem_gnt;
    wr_take    = !up_gnt && up_wr_req && !up_rd_req;
    wr_coal_go = wr_take && wr_coal;
    push       = wr_take && !wr_coal && (count_q != CNT_W'(DEPTH) || pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: begin
        if (rd_miss_go)             state_d = M_READ;
        else if (count_q != '0)     state_d = M_DRAIN;
      end
      M_READ:  if (mem_gnt) state_d = M_IDLE;
      M_DRAIN: if (mem_gnt) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= M_IDLE;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      rd_addr_q  <= '0;
      up_gnt     <= 1'b0;
      up_rd_line <= '0;
    end else begin
      state_q <= state_d;
      up_gnt  <= rd_hit_go || push || wr_coal_go || (state_q == M_READ && mem_gnt);
      if (rd_miss_go) rd_addr_q <= up_addr;
      if (rd_hit_go)                        up_rd_line <= line_q[rd_hit_idx];
      else if (state_q == M_READ && mem_gnt) up_rd_line <= mem_rd_line;
      // Pop before push so a simultaneous pop/push on a full ring keeps the slot valid.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_at(head_q, 1);
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_at(tail_q, 1);
      end
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= up_addr;
      line_q[tail_q] <= up_wr_line;
    end else if (wr_coal_go) begin
      line_q[wr_coal_idx] <= up_wr_line;
    end
  end

  assign mem_rd_req  = state_q == M_READ;
  assign mem_wr_req  = state_q == M_DRAIN;
  assign mem_addr    = (state_q == M_READ)  ? rd_addr_q :
                       (state_q == M_DRAIN) ? addr_q[head_q] : '0;
  assign mem_wr_line = (state_q == M_DRAIN) ? line_q[head_q] : '0;
  assign buf_count   = count_q;

endmodule

// File: tb/tb_cache_write_buffer.sv
// Scoreboard bench for cache_write_buffer: expected read data comes from a last-write-wins
// view of memory, and a behavioural main_mem answers the buffer's downstream requests.
module tb_cache_write_buffer;
  localparam int LAW = 3, AW = 9, DEPTH = 4, LS = 8, LW = 256, CW = 3;
`ifdef WB_COALESCE_EN
  localparam int T5_CNT = 2;
`else
  localparam int T5_CNT = 3;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] up_addr = '0, mem_addr;
  logic up_rd_req = 1'b0, up_wr_req = 1'b0, up_gnt, mem_rd_req, mem_wr_req, mem_gnt;
  logic [LW-1:0] up_rd_line, up_wr_line = '0, mem_rd_line, mem_wr_line;
  logic [CW-1:0] buf_count;

  cache_write_buffer #(.LINE_ADDR_LEN(LAW), .ADDR_LEN(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .up_addr(up_addr), .up_rd_req(up_rd_req), .up_rd_line(up_rd_line),
    .up_wr_req(up_wr_req), .up_wr_line(up_wr_line), .up_gnt(up_gnt), .mem_addr(mem_addr),
    .mem_rd_req(mem_rd_req), .mem_rd_line(mem_rd_line), .mem_wr_req(mem_wr_req),
    .mem_wr_line(mem_wr_line), .mem_gnt(mem_gnt), .buf_count(buf_count));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_rd; logic [LW-1:0] line; } exp_t;
  exp_t exp_q[$];
  logic [LW-1:0] shadow [int];
  logic [LW-1:0] mem_model [int];

  function automatic logic [LW-1:0] mem_init(input int a);
    if (a == 'h0FF) return {LS{32'hDEAD_BEEF}};
    return {LS{32'hA500_0000 | 32'(a)}};
  endfunction
  function automatic logic [LW-1:0] expect_line(input int a);
    return shadow.exists(a) ? shadow[a] : mem_init(a);
  endfunction
  function automatic logic [LW-1:0] mem_read(input int a);
    return mem_model.exists(a) ? mem_model[a] : mem_init(a);
  endfunction
  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int k = 0; k < LS; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // main_mem model
  bit mem_hold = 1'b0;
  int mem_lat = 0, busy = 0, target = 0, last_mem_gnt_cyc = -1;
  initial begin
    mem_gnt = 1'b0;
    mem_rd_line = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rd_line = rnd_line();
      if (rst) busy = 0;
      else if ((mem_rd_req || mem_wr_req) && !mem_hold) begin
        if (busy == 0) target = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 6));
        if (busy >= target) begin
          mem_gnt = 1'b1;
          last_mem_gnt_cyc = cyc;
          if (mem_wr_req) mem_model[int'(mem_addr)] = mem_wr_line;
          else            mem_rd_line = mem_read(int'(mem_addr));
          busy = 0;
        end else busy++;
      end
    end
  end

  // Monitor: pops the scoreboard on every completion.
  bit prev_gnt = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (up_gnt) begin
          chk("gnt_single_pulse", LW'(prev_gnt), '0);
          if (exp_q.size() == 0) chk("gnt_expected", LW'(1), '0);
          else begin
            e = exp_q.pop_front();
            if (e.is_rd) chk("rd_line", up_rd_line, e.line);
          end
        end
        if (!mem_rd_req && !mem_wr_req) chk("mem_addr_idle", LW'(mem_addr), '0);
      end
      prev_gnt = up_gnt;
    end
  end

  task automatic do_write(input int a, input logic [LW-1:0] d, output int lat);
    exp_t e;
    @(negedge clk);
    e.is_rd = 1'b0; e.line = d;
    exp_q.push_back(e);
    shadow[a] = d;
    up_addr = AW'(a); up_wr_line = d; up_wr_req = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!up_gnt && lat < 400);
    up_wr_req = 1'b0;
    if (!up_gnt) begin
      $display("FAIL wr_timeout: addr %0h got no up_gnt after %0d cycles", a, lat);
      $fatal(1, "write timeout");
    end
  endtask

  task automatic do_read(input int a, output int lat, output bit saw_rd, output int gnt_cyc);
    exp_t e;
    @(negedge clk);
    e.is_rd = 1'b1; e.line = expect_line(a);
    exp_q.push_back(e);
    up_addr = AW'(a); up_rd_req = 1'b1;
    lat = 0; saw_rd = 1'b0;
    do begin
      @(negedge clk); lat++;
      if (mem_rd_req) saw_rd = 1'b1;
    end while (!up_gnt && lat < 400);
    gnt_cyc = cyc;
    up_rd_req = 1'b0;
    if (!up_gnt) begin
      $display("FAIL rd_timeout: addr %0h got no up_gnt after %0d cycles", a, lat);
      $fatal(1, "read timeout");
    end
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (buf_count != 0 && n < 500) begin @(negedge clk); n++; end
    chk(name, LW'(buf_count), '0);
  endtask

  initial begin
    int lat, lat5, gc, n;
    bit saw;
    logic [LW-1:0] d;

    @(negedge clk);
    chk("rst_up_gnt", LW'(up_gnt), '0);
    chk("rst_count", LW'(buf_count), '0);
    chk("rst_rd_line", up_rd_line, '0);
    chk("rst_mem_req", LW'({mem_rd_req, mem_wr_req}), '0);
    chk("rst_mem_addr", LW'(mem_addr), '0);
    rst = 1'b0;

    // 1: single write then drain
    mem_hold = 1'b1;
    d = {LS{32'h1111_1111}};
    do_write('h012, d, lat);
    chk("t1_wr_lat", LW'(lat), LW'(1));
    chk("t1_count", LW'(buf_count), LW'(1));
    n = 0;
    while (!mem_wr_req && n < 20) begin @(negedge clk); n++; end
    chk("t1_drain_req", LW'(mem_wr_req), LW'(1));
    chk("t1_drain_addr", LW'(mem_addr), LW'('h012));
    chk("t1_drain_line", mem_wr_line, d);
    mem_hold = 1'b0;
    wait_empty("t1_empty");
    chk("t1_mem", mem_read('h012), d);

    // 2: read hit on buffered line
    mem_hold = 1'b1;
    do_write('h034, rnd_line(), lat);
    do_read('h034, lat, saw, gc);
    chk("t2_rd_lat", LW'(lat), LW'(1));
    chk("t2_no_mem_rd", LW'(saw), '0);
    mem_hold = 1'b0;
    wait_empty("t2_empty");

    // 3: read miss served from memory
    mem_lat = 4;
    do_read('h0FF, lat, saw, gc);
    chk("t3_mem_rd", LW'(saw), LW'(1));
    chk("t3_gnt_after_mem", LW'(gc - last_mem_gnt_cyc), LW'(1));
    mem_lat = 0;

    // 4: full buffer stalls a write until a drain pop
    mem_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      do_write('h1A0 + i, rnd_line(), lat);
      chk("t4_wr_lat", LW'(lat), LW'(1));
    end
    chk("t4_full", LW'(buf_count), LW'(DEPTH));
    fork
      do_write('h1A0 + DEPTH, rnd_line(), lat5);
      begin
        repeat (8) @(negedge clk);
        chk("t4_stalled", LW'(up_wr_req), LW'(1));
        chk("t4_full_stall", LW'(buf_count), LW'(DEPTH));
        mem_hold = 1'b0;
      end
    join
    chk("t4_gnt_late", LW'(lat5 > 8), LW'(1));
    chk("t4_count_kept", LW'(buf_count), LW'(DEPTH));
    wait_empty("t4_empty");

    // 5: duplicate writes; youngest data must be returned
    mem_hold = 1'b1;
    do_write('h051, rnd_line(), lat);
    do_write('h050, rnd_line(), lat);
    do_write('h050, rnd_line(), lat);
    chk("t5_count", LW'(buf_count), LW'(T5_CNT));
    do_read('h050, lat, saw, gc);
    chk("t5_rd_lat", LW'(lat), LW'(1));
    chk("t5_no_mem_rd", LW'(saw), '0);
    mem_hold = 1'b0;
    wait_empty("t5_empty");

    // 6: reset while draining drops buffered lines
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_write('h100 + i, rnd_line(), lat);
    repeat (2) @(negedge clk);
    chk("t6_count3", LW'(buf_count), LW'(3));
    chk("t6_draining", LW'(mem_wr_req), LW'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_count", LW'(buf_count), '0);
    chk("t6_rst_wr_req", LW'(mem_wr_req), '0);
    chk("t6_rst_gnt", LW'(up_gnt), '0);
    rst = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 3; i++) shadow.delete('h100 + i);
    do_read('h101, lat, saw, gc);
    chk("t6_rd_from_mem", LW'(saw), LW'(1));

    // Random traffic over a small address window to force hits and duplicates
    mem_lat = -1;
    for (int k = 0; k < 400; k++) begin
      int a;
      a = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) do_read(a, lat, saw, gc);
      else                           do_write(a, rnd_line(), lat);
    end
    wait_empty("rand_empty");
    repeat (4) @(negedge clk);
    for (int a = 0; a < 16; a++) chk($sformatf("final_mem_%0h", a), mem_read(a), expect_line(a));
    chk("scoreboard_drained", LW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
